// File: rtl/mcs51_pkg.sv
// Shared definitions for the 8051 external-bus slave: FSM encoding and bus defaults.
package mcs51_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWrWait = 2'd1,
        StRdAct  = 2'd2
    } mcs51_state_e;

    localparam logic [15:0] DefaultBaseAddr = 16'hF000;
    localparam logic [7:0]  DefaultMissData = 8'h88;
    localparam int unsigned SyncDepth       = 2;

endpackage

// File: rtl/mcs51_edge_sync.sv
// Synchroniser for one asynchronous bus strobe, with fall/rise pulses on the synced level.
module mcs51_edge_sync
    import mcs51_pkg::*;
#(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic sync_o,
    output logic fall_o,
    output logic rise_o
);

    logic [SyncDepth-1:0] sync_q;
    logic                 prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {SyncDepth{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[SyncDepth-2:0], d_i};
            prev_q <= sync_q[SyncDepth-1];
        end
    end

    assign sync_o = sync_q[SyncDepth-1];
    assign fall_o = prev_q & ~sync_o;
    assign rise_o = ~prev_q & sync_o;

endmodule

// File: rtl/mcs51_bus_regs.sv
// 8051 MOVX slave register file: ALE-latched decode, delayed write commit, read-back onto P0.
module mcs51_bus_regs
    import mcs51_pkg::*;
#(
    parameter logic [15:0]         BASE_ADDR = DefaultBaseAddr,
    parameter int unsigned         N_REGS    = 8,
    parameter logic [N_REGS-1:0]   RO_MASK   = '0,
    parameter logic [8*N_REGS-1:0] RESET_VAL = '0,
    parameter int unsigned         WR_DLY    = 2,
    parameter logic [7:0]          MISS_DATA = DefaultMissData
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mcu_ale,
    input  logic                  mcu_wr_n,
    input  logic                  mcu_rd_n,
    input  logic [7:0]            mcu_p2,
    input  logic [7:0]            mcu_p0_i,
    output logic [7:0]            mcu_p0_o,
    output logic                  mcu_p0_oe,
    output logic [8*N_REGS-1:0]   reg_q,
    output logic [N_REGS-1:0]     reg_wstb,
    input  logic [8*N_REGS-1:0]   stat_in,
    output logic [7:0]            err_cnt
);

    localparam int unsigned IdxW = $clog2(N_REGS);

    logic ale_sync, ale_fall, ale_rise;
    logic wr_sync, wr_fall, wr_rise;
    logic rd_sync, rd_fall, rd_rise;

    mcs51_edge_sync #(.ResetVal(1'b0)) u_sync_ale (
        .clk_i(clk), .reset_i(reset), .d_i(mcu_ale),
        .sync_o(ale_sync), .fall_o(ale_fall), .rise_o(ale_rise)
    );
    mcs51_edge_sync #(.ResetVal(1'b1)) u_sync_wr (
        .clk_i(clk), .reset_i(reset), .d_i(mcu_wr_n),
        .sync_o(wr_sync), .fall_o(wr_fall), .rise_o(wr_rise)
    );
    mcs51_edge_sync #(.ResetVal(1'b1)) u_sync_rd (
        .clk_i(clk), .reset_i(reset), .d_i(mcu_rd_n),
        .sync_o(rd_sync), .fall_o(rd_fall), .rise_o(rd_rise)
    );

    // Only levels and fall pulses drive the FSM.
    logic unused_edges;
    assign unused_edges = ale_fall ^ ale_rise ^ wr_rise ^ rd_rise;

    logic [7:0]        p0_s1_q, p0_sync_q;
    logic [15:0]       addr_q;
    logic [7:0]        regs_q [N_REGS];
    logic [7:0]        regs_d [N_REGS];
    logic [N_REGS-1:0] wstb_q, wstb_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        err_q, err_d;
    logic              rd_act_q, rd_act_d;
    logic [2:0]        dly_q, dly_d;
    logic              done_q, done_d;
    mcs51_state_e      state_q, state_d;

    logic            hit;
    logic [IdxW-1:0] idx;
    logic [7:0]      rd_val;
    logic            err_inc;

    assign hit = addr_q[15:IdxW] == BASE_ADDR[15:IdxW];
    assign idx = addr_q[IdxW-1:0];

    always_comb begin
        rd_val = MISS_DATA;
        if (hit) begin
            rd_val = RO_MASK[idx] ? stat_in[8*idx +: 8] : regs_q[idx];
        end
    end

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        wstb_d   = '0;
        rdata_d  = rdata_q;
        rd_act_d = rd_act_q;
        dly_d    = dly_q;
        done_d   = done_q;
        err_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_fall) begin
                    dly_d   = 3'(WR_DLY);
                    done_d  = 1'b0;
                    state_d = StWrWait;
                    err_inc = rd_fall;
                end else if (rd_fall) begin
                    rdata_d  = rd_val;
                    rd_act_d = 1'b1;
                    state_d  = StRdAct;
                end
            end
            StWrWait: begin
                err_inc = rd_fall | wr_fall;
                if (wr_sync) begin
                    // WR# released before the data sample point: abort.
                    if (!done_q) err_inc = 1'b1;
                    state_d = StIdle;
                end else if (dly_q != 3'd0) begin
                    dly_d = dly_q - 3'd1;
                end else if (!done_q) begin
                    done_d = 1'b1;
                    if (hit) begin
                        wstb_d[idx] = 1'b1;
                        if (!RO_MASK[idx]) regs_d[idx] = p0_sync_q;
                    end
                end
            end
            StRdAct: begin
                err_inc = rd_fall | wr_fall;
                if (rd_sync) begin
                    rd_act_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p0_s1_q   <= '0;
            p0_sync_q <= '0;
            addr_q    <= '0;
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VAL[8*i +: 8];
            wstb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
            rd_act_q  <= 1'b0;
            dly_q     <= '0;
            done_q    <= 1'b0;
            state_q   <= StIdle;
        end else begin
            p0_s1_q   <= mcu_p0_i;
            p0_sync_q <= p0_s1_q;
            if (ale_sync) addr_q <= {mcu_p2, p0_sync_q};
            regs_q    <= regs_d;
            wstb_q    <= wstb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rd_act_q  <= rd_act_d;
            dly_q     <= dly_d;
            done_q    <= done_d;
            state_q   <= state_d;
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_flat
        assign reg_q[8*g +: 8] = regs_q[g];
    end

    // Raw RD# so the bus is released the instant the MCU ends the read.
    assign mcu_p0_oe = rd_act_q & ~mcu_rd_n;
    assign mcu_p0_o  = rdata_q;
    assign reg_wstb  = wstb_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_mcs51_bus_regs.sv
// Directed bench for mcs51_bus_regs: write/read timing, RO, miss, protocol errors, reset.
module tb_mcs51_bus_regs;

    localparam logic [63:0] RV = 64'h1122334455667788;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mcu_ale = 1'b0;
    logic        mcu_wr_n = 1'b1;
    logic        mcu_rd_n = 1'b1;
    logic [7:0]  mcu_p2 = '0;
    logic [7:0]  mcu_p0_i = '0;
    logic [7:0]  mcu_p0_o;
    logic        mcu_p0_oe;
    logic [63:0] reg_q;
    logic [7:0]  reg_wstb;
    logic [63:0] stat_in = 64'h5A00_0000_0000_0000;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    mcs51_bus_regs #(
        .N_REGS(8), .RO_MASK(8'h80), .RESET_VAL(RV), .WR_DLY(4)
    ) dut (
        .clk(clk), .reset(reset), .mcu_ale(mcu_ale), .mcu_wr_n(mcu_wr_n),
        .mcu_rd_n(mcu_rd_n), .mcu_p2(mcu_p2), .mcu_p0_i(mcu_p0_i),
        .mcu_p0_o(mcu_p0_o), .mcu_p0_oe(mcu_p0_oe), .reg_q(reg_q),
        .reg_wstb(reg_wstb), .stat_in(stat_in), .err_cnt(err_cnt)
    );

    always #10 clk = ~clk;

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic addr_phase(input logic [15:0] addr);
        @(negedge clk);
        mcu_ale = 1'b1; mcu_p2 = addr[15:8]; mcu_p0_i = addr[7:0];
        repeat (4) @(negedge clk);
        mcu_ale = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int low,
                            output logic [7:0] seen);
        addr_phase(addr);
        mcu_p0_i = data;
        seen = '0;
        @(negedge clk); mcu_wr_n = 1'b0;
        repeat (low) begin @(negedge clk); seen |= reg_wstb; end
        mcu_wr_n = 1'b1;
        repeat (5) begin @(negedge clk); seen |= reg_wstb; end
    endtask

    task automatic do_read(input logic [15:0] addr, output logic oe_low, output logic [7:0] data,
                           output logic oe_high);
        addr_phase(addr);
        @(negedge clk); mcu_rd_n = 1'b0;
        repeat (5) @(negedge clk);
        oe_low = mcu_p0_oe; data = mcu_p0_o;
        mcu_rd_n = 1'b1;
        #1 oe_high = mcu_p0_oe;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (reg_q !== RV) begin failures++; $display("FAIL reset_reg got=%h exp=%h", reg_q, RV); end
        checks++; if (reg_wstb !== 8'h00) begin failures++; $display("FAIL reset_wstb got=%h exp=00", reg_wstb); end
        checks++; if (mcu_p0_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", mcu_p0_oe); end
        checks++; if (mcu_p0_o !== 8'h00) begin failures++; $display("FAIL reset_p0o got=%h exp=00", mcu_p0_o); end
        checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err got=%h exp=00", err_cnt); end
    endtask

    task automatic test_write();
        addr_phase(16'hF002);
        mcu_p0_i = 8'h3C;
        @(negedge clk); mcu_wr_n = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (reg_q !== RV) begin failures++; $display("FAIL wr_early got=%h exp=%h", reg_q, RV); end
        @(negedge clk);
        checks++; if (reg_q !== 64'h11223344553C7788) begin failures++; $display("FAIL wr_data got=%h exp=11223344553c7788", reg_q); end
        checks++; if (reg_wstb !== 8'h04) begin failures++; $display("FAIL wr_stb got=%h exp=04", reg_wstb); end
        @(negedge clk);
        checks++; if (reg_wstb !== 8'h00) begin failures++; $display("FAIL wr_stb_len got=%h exp=00", reg_wstb); end
        repeat (2) @(negedge clk);
        mcu_wr_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL wr_err got=%h exp=00", err_cnt); end
    endtask

    task automatic test_read();
        logic [7:0] seen, data;
        logic oe_low, oe_high;
        do_write(16'hF005, 8'hA7, 10, seen);
        checks++; if (seen !== 8'h20) begin failures++; $display("FAIL rd_prewr_stb got=%h exp=20", seen); end
        do_read(16'hF005, oe_low, data, oe_high);
        checks++; if (oe_low !== 1'b1) begin failures++; $display("FAIL rd_oe_low got=%b exp=1", oe_low); end
        checks++; if (data !== 8'hA7) begin failures++; $display("FAIL rd_data got=%h exp=a7", data); end
        checks++; if (oe_high !== 1'b0) begin failures++; $display("FAIL rd_oe_release got=%b exp=0", oe_high); end
    endtask

    task automatic test_read_only();
        logic [7:0] seen, data;
        logic oe_low, oe_high;
        do_read(16'hF007, oe_low, data, oe_high);
        checks++; if (data !== 8'h5A) begin failures++; $display("FAIL ro_read got=%h exp=5a", data); end
        do_write(16'hF007, 8'hFF, 10, seen);
        checks++; if (seen !== 8'h80) begin failures++; $display("FAIL ro_stb got=%h exp=80", seen); end
        checks++; if (reg_q[63:56] !== 8'h11) begin failures++; $display("FAIL ro_keep got=%h exp=11", reg_q[63:56]); end
    endtask

    task automatic test_miss();
        logic [7:0] seen, data;
        logic oe_low, oe_high;
        do_write(16'h1234, 8'h42, 10, seen);
        checks++; if (seen !== 8'h00) begin failures++; $display("FAIL miss_stb got=%h exp=00", seen); end
        checks++; if (reg_q !== 64'h1122A744553C7788) begin failures++; $display("FAIL miss_reg got=%h exp=1122a744553c7788", reg_q); end
        do_read(16'h1234, oe_low, data, oe_high);
        checks++; if (data !== 8'h88) begin failures++; $display("FAIL miss_read got=%h exp=88", data); end
        checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL miss_err got=%h exp=00", err_cnt); end
    endtask

    task automatic test_short_write();
        logic [7:0] seen;
        do_reset();
        do_write(16'hF001, 8'h55, 2, seen);
        checks++; if (err_cnt !== 8'h01) begin failures++; $display("FAIL short_err got=%h exp=01", err_cnt); end
        checks++; if (reg_q !== RV) begin failures++; $display("FAIL short_reg got=%h exp=%h", reg_q, RV); end
        checks++; if (seen !== 8'h00) begin failures++; $display("FAIL short_stb got=%h exp=00", seen); end
    endtask

    task automatic test_wr_rd_collision();
        logic oe_seen;
        do_reset();
        addr_phase(16'hF003);
        mcu_p0_i = 8'h9E;
        oe_seen = 1'b0;
        @(negedge clk); mcu_wr_n = 1'b0; mcu_rd_n = 1'b0;
        repeat (10) begin @(negedge clk); oe_seen |= mcu_p0_oe; end
        mcu_wr_n = 1'b1; mcu_rd_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (reg_q !== 64'h112233449E667788) begin failures++; $display("FAIL coll_reg got=%h exp=112233449e667788", reg_q); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL coll_oe got=%b exp=0", oe_seen); end
        checks++; if (err_cnt !== 8'h01) begin failures++; $display("FAIL coll_err got=%h exp=01", err_cnt); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] seen;
        do_reset();
        do_write(16'hF001, 8'h55, 2, seen);
        do_write(16'hF000, 8'hA5, 10, seen);
        addr_phase(16'hF000);
        @(negedge clk); mcu_rd_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (mcu_p0_oe !== 1'b1) begin failures++; $display("FAIL midrst_pre_oe got=%b exp=1", mcu_p0_oe); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (mcu_p0_oe !== 1'b0) begin failures++; $display("FAIL midrst_oe got=%b exp=0", mcu_p0_oe); end
        checks++; if (reg_q !== RV) begin failures++; $display("FAIL midrst_reg got=%h exp=%h", reg_q, RV); end
        checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL midrst_err got=%h exp=00", err_cnt); end
        checks++; if (mcu_p0_o !== 8'h00) begin failures++; $display("FAIL midrst_p0o got=%h exp=00", mcu_p0_o); end
        mcu_rd_n = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_only();
        test_miss();
        test_short_write();
        test_wr_rd_collision();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
